regfile_write_port: RTL and testbench

Write-side companion to the register file read multiplexer: accepts register write-back requests over a valid/ready handshake, buffers them in a small FIFO, and retires one per cycle into a 32 x 32-bit register bank. All 32 registers are exposed in parallel as `Reg0`..`Reg31`, which feed the In0..In31 inputs of the read multiplexers. It also provides a sequenced bank-clear operation for soft reinitialisation without asserting reset.

---
 rtl/regfile_write_port.sv | 195 +++++++++++++++++++
 tb/tb_regfile_write_port.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// Buffered write port for a 32 x 32-bit register bank, with a sequenced bank clear.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_write_port #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     WrValid,
    output logic                     WrReady,
    input  logic [4:0]               WriteRegister,
    input  logic [31:0]              WriteData,
    input  logic                     ClearReq,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   Pending,
    output logic [31:0]              Reg0,
    output logic [31:0]              Reg1,
    output logic [31:0]              Reg2,
    output logic [31:0]              Reg3,
    output logic [31:0]              Reg4,
    output logic [31:0]              Reg5,
    output logic [31:0]              Reg6,
    output logic [31:0]              Reg7,
    output logic [31:0]              Reg8,
    output logic [31:0]              Reg9,
    output logic [31:0]              Reg10,
    output logic [31:0]              Reg11,
    output logic [31:0]              Reg12,
    output logic [31:0]              Reg13,
    output logic [31:0]              Reg14,
    output logic [31:0]              Reg15,
    output logic [31:0]              Reg16,
    output logic [31:0]              Reg17,
    output logic [31:0]              Reg18,
    output logic [31:0]              Reg19,
    output logic [31:0]              Reg20,
    output logic [31:0]              Reg21,
    output logic [31:0]              Reg22,
    output logic [31:0]              Reg23,
    output logic [31:0]              Reg24,
    output logic [31:0]              Reg25,
    output logic [31:0]              Reg26,
    output logic [31:0]              Reg27,
    output logic [31:0]              Reg28,
    output logic [31:0]              Reg29,
    output logic [31:0]              Reg30,
    output logic [31:0]              Reg31
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e      state_q, state_d;
    logic        clr_pending_q, clr_pending_d;
    logic [4:0]  clr_cnt_q, clr_cnt_d;

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]  fifo_reg  [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic        full, empty, push, pop, last_pop;

    logic [31:0] regs_q [32];
    logic [31:0] we;
    logic [31:0] wdata;

    // Extra MSB on the pointers separates full from empty.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign WrReady  = !full && (state_q == StIdle) && !clr_pending_q;
    assign push     = WrValid && WrReady;
    assign pop      = !empty && ((state_q == StIdle) || (state_q == StDrain));
    assign last_pop = pop && ((rd_ptr_q + PtrOne) == wr_ptr_q);
    assign Pending  = wr_ptr_q - rd_ptr_q;
    assign Busy     = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr_q[AW-1:0]]  <= WriteRegister;
            fifo_data[wr_ptr_q[AW-1:0]] <= WriteData;
        end
    end

    always_comb begin
        state_d       = state_q;
        clr_pending_d = clr_pending_q;
        clr_cnt_d     = clr_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ClearReq) begin
                    clr_pending_d = 1'b1;
                    clr_cnt_d     = '0;
                    state_d       = empty ? StClear : StDrain;
                end
            end
            StDrain: begin
                // Nothing is pushed here, so the queue only shrinks.
                if (empty || last_pop) begin
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) begin
                    state_d       = StIdle;
                    clr_pending_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            clr_pending_q <= 1'b0;
            clr_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            clr_pending_q <= clr_pending_d;
            clr_cnt_q     <= clr_cnt_d;
        end
    end

    always_comb begin
        we    = '0;
        wdata = fifo_data[rd_ptr_q[AW-1:0]];
        if (state_q == StClear) begin
            we[clr_cnt_q] = 1'b1;
            wdata         = '0;
        end else if (pop) begin
            we[fifo_reg[rd_ptr_q[AW-1:0]]] = 1'b1;
        end
`ifdef REGFILE_R0_ZERO_EN
        // Writes to r0 still pop, but never reach the bank.
        we[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (we[i]) regs_q[i] <= wdata;
            end
        end
    end

    assign Reg0  = regs_q[0];
    assign Reg1  = regs_q[1];
    assign Reg2  = regs_q[2];
    assign Reg3  = regs_q[3];
    assign Reg4  = regs_q[4];
    assign Reg5  = regs_q[5];
    assign Reg6  = regs_q[6];
    assign Reg7  = regs_q[7];
    assign Reg8  = regs_q[8];
    assign Reg9  = regs_q[9];
    assign Reg10 = regs_q[10];
    assign Reg11 = regs_q[11];
    assign Reg12 = regs_q[12];
    assign Reg13 = regs_q[13];
    assign Reg14 = regs_q[14];
    assign Reg15 = regs_q[15];
    assign Reg16 = regs_q[16];
    assign Reg17 = regs_q[17];
    assign Reg18 = regs_q[18];
    assign Reg19 = regs_q[19];
    assign Reg20 = regs_q[20];
    assign Reg21 = regs_q[21];
    assign Reg22 = regs_q[22];
    assign Reg23 = regs_q[23];
    assign Reg24 = regs_q[24];
    assign Reg25 = regs_q[25];
    assign Reg26 = regs_q[26];
    assign Reg27 = regs_q[27];
    assign Reg28 = regs_q[28];
    assign Reg29 = regs_q[29];
    assign Reg30 = regs_q[30];
    assign Reg31 = regs_q[31];

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: writes, back-to-back traffic, r0, clears and resets.
module tb_regfile_write_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic [2:0]  pending;
    logic [31:0] regs [32];

    int n_vec = 0;
    int n_bad = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    regfile_write_port #(.DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .WrValid(wr_valid), .WrReady(wr_ready),
        .WriteRegister(wr_reg), .WriteData(wr_data), .ClearReq(clr_req),
        .Busy(busy), .Pending(pending),
        .Reg0(regs[0]),   .Reg1(regs[1]),   .Reg2(regs[2]),   .Reg3(regs[3]),
        .Reg4(regs[4]),   .Reg5(regs[5]),   .Reg6(regs[6]),   .Reg7(regs[7]),
        .Reg8(regs[8]),   .Reg9(regs[9]),   .Reg10(regs[10]), .Reg11(regs[11]),
        .Reg12(regs[12]), .Reg13(regs[13]), .Reg14(regs[14]), .Reg15(regs[15]),
        .Reg16(regs[16]), .Reg17(regs[17]), .Reg18(regs[18]), .Reg19(regs[19]),
        .Reg20(regs[20]), .Reg21(regs[21]), .Reg22(regs[22]), .Reg23(regs[23]),
        .Reg24(regs[24]), .Reg25(regs[25]), .Reg26(regs[26]), .Reg27(regs[27]),
        .Reg28(regs[28]), .Reg29(regs[29]), .Reg30(regs[30]), .Reg31(regs[31])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_req(input logic [4:0] r, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_reg   = r;
        wr_data  = d;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) check(tag, regs[i], 32'h0);
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_reg   = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Reset state
        check("rst_ready", 32'(wr_ready), 32'h1);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check_all_zero("rst_regs");

        // Single write: accepted at N, visible after N+1
        write_req(5'd5, 32'hDEADBEEF);
        tick();
        wr_valid = 1'b0;
        check("single_pend1", 32'(pending), 32'h1);
        check("single_r5_early", regs[5], 32'h0);
        tick();
        check("single_r5", regs[5], 32'hDEADBEEF);
        check("single_pend0", 32'(pending), 32'h0);

        // Back-to-back writes: a pop every cycle keeps WrReady high
        for (int i = 1; i <= 6; i++) begin
            write_req(5'(i), 32'h11 * 32'(i));
            check("bp_ready", 32'(wr_ready), 32'h1);
            tick();
            check("bp_pending", 32'(pending), 32'h1);
        end
        write_req(5'd3, 32'hAA);
        check("bp_ready", 32'(wr_ready), 32'h1);
        tick();
        write_req(5'd3, 32'hBB);
        check("bp_ready", 32'(wr_ready), 32'h1);
        tick();
        wr_valid = 1'b0;
        tick();
        check("bp_pend0", 32'(pending), 32'h0);
        check("bp_r1", regs[1], 32'h11);
        check("bp_r2", regs[2], 32'h22);
        check("bp_r3_last_wins", regs[3], 32'hBB);
        check("bp_r4", regs[4], 32'h44);
        check("bp_r5", regs[5], 32'h55);
        check("bp_r6", regs[6], 32'h66);

        // Register 0 write
        write_req(5'd0, 32'h12345678);
        tick();
        wr_valid = 1'b0;
        check("r0_pend1", 32'(pending), 32'h1);
        tick();
        check("r0_pend0", 32'(pending), 32'h0);
`ifdef REGFILE_R0_ZERO_EN
        check("r0_value", regs[0], 32'h0);
`else
        check("r0_value", regs[0], 32'h12345678);
`endif

        // Clear with backlog: ClearReq arrives with the third write
        write_req(5'd20, 32'h2020);
        tick();
        write_req(5'd21, 32'h2121);
        tick();
        write_req(5'd22, 32'h2222);
        clr_req = 1'b1;
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        check("clrb_busy", 32'(busy), 32'h1);
        check("clrb_ready", 32'(wr_ready), 32'h0);
        check("clrb_pending", 32'(pending), 32'h1);
        busy_cycles = 1;
        for (int k = 0; k < 100 && busy; k++) begin
            tick();
            if (k == 0) begin
                check("clrb_r20", regs[20], 32'h2020);
                check("clrb_r21", regs[21], 32'h2121);
                check("clrb_r22", regs[22], 32'h2222);
                check("clrb_pend0", 32'(pending), 32'h0);
            end
            if (busy) begin
                busy_cycles++;
                check("clrb_ready_low", 32'(wr_ready), 32'h0);
            end
        end
        check("clrb_busy_len", 32'(busy_cycles), 32'd33);
        check("clrb_ready_after", 32'(wr_ready), 32'h1);
        check_all_zero("clrb_regs");

        // Clear from empty: reg k zeroed at edge N+1+k
        write_req(5'd1, 32'h0101);
        tick();
        write_req(5'd31, 32'h3131);
        tick();
        wr_valid = 1'b0;
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clre_busy", 32'(busy), 32'h1);
        check("clre_r1_n", regs[1], 32'h0101);
        tick();
        check("clre_r1_n1", regs[1], 32'h0101);
        tick();
        check("clre_r1_n2", regs[1], 32'h0);
        repeat (29) tick();
        check("clre_r31_n31", regs[31], 32'h3131);
        check("clre_busy_n31", 32'(busy), 32'h1);
        tick();
        check("clre_r31_n32", regs[31], 32'h0);
        check("clre_busy_n32", 32'(busy), 32'h0);
        check("clre_ready", 32'(wr_ready), 32'h1);

        // Reset ten cycles into a clear
        write_req(5'd25, 32'h25);
        tick();
        wr_valid = 1'b0;
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        check("rmc_busy_pre", 32'(busy), 32'h1);
        check("rmc_r25_pre", regs[25], 32'h25);
        reset_n = 1'b0;
        #1;
        check("rmc_busy", 32'(busy), 32'h0);
        check("rmc_pending", 32'(pending), 32'h0);
        check_all_zero("rmc_regs");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rmc_ready", 32'(wr_ready), 32'h1);
        write_req(5'd31, 32'h1);
        tick();
        wr_valid = 1'b0;
        tick();
        check("rmc_r31", regs[31], 32'h1);
        check("rmc_pend0", 32'(pending), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
